// File: rtl/fft_pkg.sv
// Shared constants for the 16-point radix-4 FFT datapath.
// It holds the operand widths, the exact double constants used by the twiddle ROM,
// the feeder FSM state encoding, and a helper that negates a double.
package fft_pkg;

    localparam int unsigned WIDTH = 64;
    localparam int unsigned N     = 16;
    localparam int unsigned IDX_W = 4;

    localparam logic [WIDTH-1:0] DBL_ZERO    = 64'h0000_0000_0000_0000;
    localparam logic [WIDTH-1:0] DBL_ONE     = 64'h3FF0_0000_0000_0000;
    localparam logic [WIDTH-1:0] DBL_NEG_ONE = 64'hBFF0_0000_0000_0000;
    // Correctly rounded cos(pi/4), cos(pi/8) and sin(pi/8).
    localparam logic [WIDTH-1:0] DBL_SQRT1_2 = 64'h3FE6_A09E_667F_3BCD;
    localparam logic [WIDTH-1:0] DBL_COS_PI8 = 64'h3FED_906B_CF32_8D46;
    localparam logic [WIDTH-1:0] DBL_SIN_PI8 = 64'h3FD8_7DE2_A6AE_A963;

    localparam int unsigned ST_W = 3;
    localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [ST_W-1:0] ST_SEND_A = 3'd1;
    localparam logic [ST_W-1:0] ST_SEND_B = 3'd2;
    localparam logic [ST_W-1:0] ST_GET_Z  = 3'd3;
    localparam logic [ST_W-1:0] ST_OUTPUT = 3'd4;

    // Negate a double by flipping its sign bit; this is exact and does no rounding.
    function automatic logic [WIDTH-1:0] dbl_neg(input logic [WIDTH-1:0] x);
        return {~x[WIDTH-1], x[WIDTH-2:0]};
    endfunction

endpackage

// File: rtl/twiddle_rom_16.sv
// Combinational twiddle ROM, W16^k = cos(pi*k/8) - j*sin(pi*k/8).
// The ROM is shared with the other FFT stages.
// Ports: k (IDX_W) is the twiddle index; cos_o and sin_o (WIDTH) are correctly rounded doubles.
module twiddle_rom_16
    import fft_pkg::*;
(
    input  logic [IDX_W-1:0] k,
    output logic [WIDTH-1:0] cos_o,
    output logic [WIDTH-1:0] sin_o
);

    // Values at multiples of pi/2 are exact. Zeros are always +0.0.
    always_comb begin
        cos_o = DBL_ZERO;
        sin_o = DBL_ZERO;
        case (k)
            4'd0:  begin cos_o = DBL_ONE;                 sin_o = DBL_ZERO;                end
            4'd1:  begin cos_o = DBL_COS_PI8;             sin_o = DBL_SIN_PI8;             end
            4'd2:  begin cos_o = DBL_SQRT1_2;             sin_o = DBL_SQRT1_2;             end
            4'd3:  begin cos_o = DBL_SIN_PI8;             sin_o = DBL_COS_PI8;             end
            4'd4:  begin cos_o = DBL_ZERO;                sin_o = DBL_ONE;                 end
            4'd5:  begin cos_o = dbl_neg(DBL_SIN_PI8);    sin_o = DBL_COS_PI8;             end
            4'd6:  begin cos_o = dbl_neg(DBL_SQRT1_2);    sin_o = DBL_SQRT1_2;             end
            4'd7:  begin cos_o = dbl_neg(DBL_COS_PI8);    sin_o = DBL_SIN_PI8;             end
            4'd8:  begin cos_o = DBL_NEG_ONE;             sin_o = DBL_ZERO;                end
            4'd9:  begin cos_o = dbl_neg(DBL_COS_PI8);    sin_o = dbl_neg(DBL_SIN_PI8);    end
            4'd10: begin cos_o = dbl_neg(DBL_SQRT1_2);    sin_o = dbl_neg(DBL_SQRT1_2);    end
            4'd11: begin cos_o = dbl_neg(DBL_SIN_PI8);    sin_o = dbl_neg(DBL_COS_PI8);    end
            4'd12: begin cos_o = DBL_ZERO;                sin_o = DBL_NEG_ONE;             end
            4'd13: begin cos_o = DBL_SIN_PI8;             sin_o = dbl_neg(DBL_COS_PI8);    end
            4'd14: begin cos_o = DBL_SQRT1_2;             sin_o = dbl_neg(DBL_SQRT1_2);    end
            4'd15: begin cos_o = DBL_COS_PI8;             sin_o = dbl_neg(DBL_SIN_PI8);    end
            default: begin cos_o = DBL_ZERO;              sin_o = DBL_ZERO;                end
        endcase
    end

endmodule

// File: rtl/twiddle_mul_feeder.sv
// Operand sequencer for double_multiplier in the 16-point radix-4 FFT.
// It takes one complex sample and a twiddle index. It then feeds the four real products
// re*cos, im*sin, re*sin and im*cos through the multiplier's stb/ack handshake, and
// presents the collected products to the adder stage.
// Ports:
//   clk, reset (asynchronous, active-low)
//   in_re/in_im/in_k/in_stb -> in_ack          sample input
//   mul_a/mul_a_stb <- mul_a_ack                operand a (re or im)
//   mul_b/mul_b_stb <- mul_b_ack                operand b (cos or sin)
//   mul_z/mul_z_stb -> mul_z_ack                product return
//   p_rc/p_is/p_rs/p_ic/out_stb <- out_ack      product output
//   busy                                        high outside IDLE
// Build option: TRIVIAL_TWIDDLE_BYPASS_EN passes k==0 samples straight to OUTPUT.
module twiddle_mul_feeder
    import fft_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_im,
    input  logic [IDX_W-1:0] in_k,
    input  logic             in_stb,
    output logic             in_ack,
    output logic [WIDTH-1:0] mul_a,
    output logic             mul_a_stb,
    input  logic             mul_a_ack,
    output logic [WIDTH-1:0] mul_b,
    output logic             mul_b_stb,
    input  logic             mul_b_ack,
    input  logic [WIDTH-1:0] mul_z,
    input  logic             mul_z_stb,
    output logic             mul_z_ack,
    output logic [WIDTH-1:0] p_rc,
    output logic [WIDTH-1:0] p_is,
    output logic [WIDTH-1:0] p_rs,
    output logic [WIDTH-1:0] p_ic,
    output logic             out_stb,
    input  logic             out_ack,
    output logic             busy
);

    logic [ST_W-1:0]  state_q, state_d;
    logic [1:0]       j_q, j_d;
    logic [WIDTH-1:0] re_q, re_d, im_q, im_d, cos_q, cos_d, sin_q, sin_d;
    logic [WIDTH-1:0] p_rc_q, p_rc_d, p_is_q, p_is_d, p_rs_q, p_rs_d, p_ic_q, p_ic_d;
    logic [WIDTH-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic             in_ack_q, in_ack_d, mul_a_stb_q, mul_a_stb_d, mul_b_stb_q, mul_b_stb_d;
    logic             mul_z_ack_q, mul_z_ack_d, out_stb_q, out_stb_d, busy_q, busy_d;
    logic [WIDTH-1:0] rom_cos, rom_sin;

    twiddle_rom_16 u_rom (
        .k     (in_k),
        .cos_o (rom_cos),
        .sin_o (rom_sin)
    );

    // State register and registered Moore outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            j_q         <= 2'd0;
            re_q        <= '0;
            im_q        <= '0;
            cos_q       <= '0;
            sin_q       <= '0;
            p_rc_q      <= '0;
            p_is_q      <= '0;
            p_rs_q      <= '0;
            p_ic_q      <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            in_ack_q    <= 1'b0;
            mul_a_stb_q <= 1'b0;
            mul_b_stb_q <= 1'b0;
            mul_z_ack_q <= 1'b0;
            out_stb_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            j_q         <= j_d;
            re_q        <= re_d;
            im_q        <= im_d;
            cos_q       <= cos_d;
            sin_q       <= sin_d;
            p_rc_q      <= p_rc_d;
            p_is_q      <= p_is_d;
            p_rs_q      <= p_rs_d;
            p_ic_q      <= p_ic_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            in_ack_q    <= in_ack_d;
            mul_a_stb_q <= mul_a_stb_d;
            mul_b_stb_q <= mul_b_stb_d;
            mul_z_ack_q <= mul_z_ack_d;
            out_stb_q   <= out_stb_d;
            busy_q      <= busy_d;
        end
    end

    // Next state. Outputs are decoded from the next state, so each strobe rises together with its state.
    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        re_d    = re_q;
        im_d    = im_q;
        cos_d   = cos_q;
        sin_d   = sin_q;
        p_rc_d  = p_rc_q;
        p_is_d  = p_is_q;
        p_rs_d  = p_rs_q;
        p_ic_d  = p_ic_q;

        case (state_q)
            ST_IDLE: begin
                // in_ack_q gates the capture so that the first cycle after reset cannot accept a sample.
                if (in_stb && in_ack_q) begin
                    re_d  = in_re;
                    im_d  = in_im;
                    cos_d = rom_cos;
                    sin_d = rom_sin;
                    j_d   = 2'd0;
`ifdef TRIVIAL_TWIDDLE_BYPASS_EN
                    if (in_k == IDX_W'(0)) begin
                        p_rc_d  = in_re;
                        p_is_d  = DBL_ZERO;
                        p_rs_d  = DBL_ZERO;
                        p_ic_d  = in_im;
                        state_d = ST_OUTPUT;
                    end else begin
                        state_d = ST_SEND_A;
                    end
`else
                    state_d = ST_SEND_A;
`endif
                end
            end
            ST_SEND_A: if (mul_a_ack) state_d = ST_SEND_B;
            ST_SEND_B: if (mul_b_ack) state_d = ST_GET_Z;
            ST_GET_Z: begin
                if (mul_z_stb) begin
                    case (j_q)
                        2'd0:    p_rc_d = mul_z;
                        2'd1:    p_is_d = mul_z;
                        2'd2:    p_rs_d = mul_z;
                        default: p_ic_d = mul_z;
                    endcase
                    if (j_q == 2'd3) begin
                        state_d = ST_OUTPUT;
                    end else begin
                        j_d     = j_q + 2'd1;
                        state_d = ST_SEND_A;
                    end
                end
            end
            ST_OUTPUT: if (out_ack) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        in_ack_d    = (state_d == ST_IDLE);
        mul_a_stb_d = (state_d == ST_SEND_A);
        mul_b_stb_d = (state_d == ST_SEND_B);
        mul_z_ack_d = (state_d == ST_GET_Z);
        out_stb_d   = (state_d == ST_OUTPUT);
        busy_d      = (state_d != ST_IDLE);
        // Term order: a = {re, im, re, im}, b = {cos, sin, sin, cos}.
        mul_a_d     = j_d[0] ? im_d : re_d;
        mul_b_d     = (j_d[0] ^ j_d[1]) ? sin_d : cos_d;
    end

    assign in_ack    = in_ack_q;
    assign mul_a     = mul_a_q;
    assign mul_a_stb = mul_a_stb_q;
    assign mul_b     = mul_b_q;
    assign mul_b_stb = mul_b_stb_q;
    assign mul_z_ack = mul_z_ack_q;
    assign p_rc      = p_rc_q;
    assign p_is      = p_is_q;
    assign p_rs      = p_rs_q;
    assign p_ic      = p_ic_q;
    assign out_stb   = out_stb_q;
    assign busy      = busy_q;

endmodule
